alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Decode-and-issue stage that drives the ALU's `alu_op`, `alu_in_0` and `alu_in_1` inputs: the producer end of the ALU operand interface.
- Accepts a fetched RV32I integer-compute instruction with its PC.
- Reads GPR source addresses, forms ALU opcode and operands in the ALU's operand convention, and holds them in a registered ID/EX stage with valid/ready flow control and flush.

Parameters:
- XLEN, 32, width of GPR data, PC and ALU operands; must equal `DATA_WIDTH_GPR`.
- OP_W, `DATA_WIDTH_ALU_OP`, width of ALU opcode field.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- if_valid  in  1  instruction/PC valid.
- if_insn  in  32  instruction word.
- if_pc  in  XLEN  PC of instruction.
- if_ready  out  1  stage can accept this cycle.
- rs1_addr  out  5  GPR read address (combinational, `if_insn[19:15]`).
- rs2_addr  out  5  GPR read address (combinational, `if_insn[24:20]`).
- rs1_data  in  XLEN  GPR read data, same cycle.
- rs2_data  in  XLEN  GPR read data, same cycle.
- flush  in  1  kill held and incoming instruction.
- ex_ready  in  1  EX consumes the held entry.
- ex_valid  out  1  held entry valid.
- ex_alu_op  out  OP_W  opcode to ALU.
- ex_alu_in_0  out  XLEN  ALU operand 0.
- ex_alu_in_1  out  XLEN  ALU operand 1.
- ex_rd_addr  out  5  destination register.
- ex_rd_we  out  1  writeback enable (0 when rd==x0).
- ex_illegal  out  1  held entry is illegal (feature only, else tied 0).

Behaviour:
- Reset (async, immediate): ex_valid=0, ex_alu_op=0, ex_alu_in_0=0, ex_alu_in_1=0, ex_rd_addr=0, ex_rd_we=0, ex_illegal=0.
- if_ready = !ex_valid | ex_ready (combinational). Transfer occurs when if_valid & if_ready. Latency is 1 cycle: a transfer in cycle N is presented on ex_* in cycle N+1.
- Hold: while ex_valid & !ex_ready, all ex_* are stable. if_insn is not sampled.
- Edge priority: flush > transfer > (ex_ready: ex_valid<=0) > hold.
  - flush=1: ex_valid<=0 and the incoming instruction is dropped even if if_valid=1. Payload registers may keep stale values.
- Decode, OP-IMM (opcode 0010011), by funct3:
  - 000 ADDI, 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI.
  - 001 SLLI, legal only if funct7=0000000.
  - 101 SRLI (funct7=0000000) / SRAI (funct7=0100000).
  - in_0 = sign-extended imm[11:0]; in_1 = rs1_data.
  - Shifts: in_0 = zero-extended shamt `if_insn[24:20]`.
- Decode, OP (opcode 0110011), by funct3/funct7:
  - funct7=0000000: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: 000 SUB, 101 SRA.
  - in_0 = rs1_data; in_1 = rs2_data.
- Decode, LUI (0110111): in_0 = zero-extended `if_insn[31:12]` (ALU shifts by 12); in_1 = 0.
- Decode, AUIPC (0010111): in_0 = zero-extended `if_insn[31:12]`; in_1 = if_pc.
- ex_rd_addr = `if_insn[11:7]`. ex_rd_we = legal & (rd!=0).
- Illegal: any other opcode or funct combination. ex_alu_op=0, both operands 0, ex_rd_we=0.
- Reset mid-hold drops the entry. The first transfer after reset release is accepted because if_ready=1.

Optional Feature:
- Macro ALU_ISSUE_ILLEGAL_TRAP_EN.
- Defined: illegal instructions transfer normally with ex_valid=1, ex_illegal=1, ex_rd_we=0.
- Undefined: illegal instructions are consumed (if_ready honoured) but ex_valid stays 0 for them. ex_illegal is constant 0.

Test Plan:
- Reset with rst pulsed mid-cycle, outputs dirty -> all ex_* 0 immediately; if_ready=1.
- ADDI x5,x1,-3 with rs1_data=10 -> next cycle: ex_valid=1, op=ADDI, in_0=0xFFFFFFFD, in_1=10, rd=5, we=1.
- SRAI x3,x2,4 then AUIPC x7,0x12345 at pc=0x100 -> in_0=4, in_1=rs1_data; then in_0=0x00012345, in_1=0x100.
- Stall: ex_ready=0 for 3 cycles with SUB held, next insn on if_valid -> if_ready=0, ex_* stable. ex_ready=1 -> next insn appears one cycle later, no loss or duplication.
- flush with ex_valid=1 and if_valid=1 same cycle -> ex_valid=0 next cycle, incoming dropped.
- Opcode 0000000 and ADD x0,x1,x2 -> illegal handled per macro setting; ADD shows we=0.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: RV32I integer-compute decode/issue stage driving the ALU operand interface.
// Build option: define ALU_ISSUE_ILLEGAL_TRAP_EN to forward illegal instructions flagged by ex_illegal.
`ifndef DATA_WIDTH_ALU_OP
`define DATA_WIDTH_ALU_OP 5
`endif

module alu_issue #(
  parameter int XLEN = 32,
  parameter int OP_W = `DATA_WIDTH_ALU_OP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_insn,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [OP_W-1:0] ex_alu_op,
  output logic [XLEN-1:0] ex_alu_in_0,
  output logic [XLEN-1:0] ex_alu_in_1,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_rd_we,
  output logic            ex_illegal
);

  // ALU opcode space; zero is reserved for "no operation" on illegal entries.
  // Immediate forms carry their own codes because the immediate sits in operand 0.
  localparam logic [OP_W-1:0] ALU_NONE  = OP_W'(0);
  localparam logic [OP_W-1:0] ALU_ADD   = OP_W'(1);
  localparam logic [OP_W-1:0] ALU_SUB   = OP_W'(2);
  localparam logic [OP_W-1:0] ALU_SLL   = OP_W'(3);
  localparam logic [OP_W-1:0] ALU_SLT   = OP_W'(4);
  localparam logic [OP_W-1:0] ALU_SLTU  = OP_W'(5);
  localparam logic [OP_W-1:0] ALU_XOR   = OP_W'(6);
  localparam logic [OP_W-1:0] ALU_SRL   = OP_W'(7);
  localparam logic [OP_W-1:0] ALU_SRA   = OP_W'(8);
  localparam logic [OP_W-1:0] ALU_OR    = OP_W'(9);
  localparam logic [OP_W-1:0] ALU_AND   = OP_W'(10);
  localparam logic [OP_W-1:0] ALU_ADDI  = OP_W'(11);
  localparam logic [OP_W-1:0] ALU_SLTI  = OP_W'(12);
  localparam logic [OP_W-1:0] ALU_SLTIU = OP_W'(13);
  localparam logic [OP_W-1:0] ALU_XORI  = OP_W'(14);
  localparam logic [OP_W-1:0] ALU_ORI   = OP_W'(15);
  localparam logic [OP_W-1:0] ALU_ANDI  = OP_W'(16);
  localparam logic [OP_W-1:0] ALU_SLLI  = OP_W'(17);
  localparam logic [OP_W-1:0] ALU_SRLI  = OP_W'(18);
  localparam logic [OP_W-1:0] ALU_SRAI  = OP_W'(19);
  localparam logic [OP_W-1:0] ALU_LUI   = OP_W'(20);
  localparam logic [OP_W-1:0] ALU_AUIPC = OP_W'(21);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] shamt;
  logic [XLEN-1:0] imm_u;

  assign opcode   = if_insn[6:0];
  assign rd       = if_insn[11:7];
  assign funct3   = if_insn[14:12];
  assign funct7   = if_insn[31:25];
  assign rs1_addr = if_insn[19:15];
  assign rs2_addr = if_insn[24:20];

  assign imm_i = {{(XLEN-12){if_insn[31]}}, if_insn[31:20]};
  assign shamt = {{(XLEN-5){1'b0}}, if_insn[24:20]};
  assign imm_u = {{(XLEN-20){1'b0}}, if_insn[31:12]};

  logic            dec_legal;
  logic [OP_W-1:0] dec_op;
  logic [XLEN-1:0] dec_in_0;
  logic [XLEN-1:0] dec_in_1;
  logic            dec_we;

  always_comb begin
    // NOTE: every decode output is defaulted first so no path through the cases infers a latch.
    dec_legal = 1'b0;
    dec_op    = ALU_NONE;
    dec_in_0  = '0;
    dec_in_1  = '0;

    case (opcode)
      OPC_OP_IMM: begin
        dec_legal = 1'b1;
        dec_in_0  = imm_i;
        dec_in_1  = rs1_data;
        case (funct3)
          3'b000: dec_op = ALU_ADDI;
          3'b010: dec_op = ALU_SLTI;
          3'b011: dec_op = ALU_SLTIU;
          3'b100: dec_op = ALU_XORI;
          3'b110: dec_op = ALU_ORI;
          3'b111: dec_op = ALU_ANDI;
          3'b001: begin
            dec_in_0  = shamt;
            dec_op    = ALU_SLLI;
            dec_legal = (funct7 == F7_BASE);
          end
          default: begin
            dec_in_0 = shamt;
            if (funct7 == F7_BASE)     dec_op = ALU_SRLI;
            else if (funct7 == F7_ALT) dec_op = ALU_SRAI;
            else                       dec_legal = 1'b0;
          end
        endcase
      end

      OPC_OP: begin
        dec_in_0 = rs1_data;
        dec_in_1 = rs2_data;
        if (funct7 == F7_BASE) begin
          dec_legal = 1'b1;
          case (funct3)
            3'b000:  dec_op = ALU_ADD;
            3'b001:  dec_op = ALU_SLL;
            3'b010:  dec_op = ALU_SLT;
            3'b011:  dec_op = ALU_SLTU;
            3'b100:  dec_op = ALU_XOR;
            3'b101:  dec_op = ALU_SRL;
            3'b110:  dec_op = ALU_OR;
            default: dec_op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000: begin
              dec_legal = 1'b1;
              dec_op    = ALU_SUB;
            end
            3'b101: begin
              dec_legal = 1'b1;
              dec_op    = ALU_SRA;
            end
            default: dec_legal = 1'b0;
          endcase
        end
      end

      // The ALU applies the 12-bit shift to the upper immediate itself.
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_op    = ALU_LUI;
        dec_in_0  = imm_u;
      end

      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_op    = ALU_AUIPC;
        dec_in_0  = imm_u;
        dec_in_1  = if_pc;
      end

      default: dec_legal = 1'b0;
    endcase

    if (!dec_legal) begin
      dec_op   = ALU_NONE;
      dec_in_0 = '0;
      dec_in_1 = '0;
    end
  end

  assign dec_we = dec_legal && (rd != 5'd0);

  logic transfer;

  assign if_ready = !ex_valid || ex_ready;
  assign transfer = if_valid && if_ready;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_alu_op   <= '0;
      ex_alu_in_0 <= '0;
      ex_alu_in_1 <= '0;
      ex_rd_addr  <= '0;
      ex_rd_we    <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      ex_illegal  <= 1'b0;
`endif
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (transfer) begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      ex_valid    <= 1'b1;
      ex_illegal  <= !dec_legal;
`else
      ex_valid    <= dec_legal;
`endif
      ex_alu_op   <= dec_op;
      ex_alu_in_0 <= dec_in_0;
      ex_alu_in_1 <= dec_in_1;
      ex_rd_addr  <= rd;
      ex_rd_we    <= dec_we;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

`ifndef ALU_ISSUE_ILLEGAL_TRAP_EN
  assign ex_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus randomized traffic
// against a transaction-level queue model of the issue slot.
`timescale 1ns/1ps

module tb_alu_issue;

  localparam logic [4:0] OP_NONE  = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_SLL   = 5'd3;
  localparam logic [4:0] OP_SLT   = 5'd4;
  localparam logic [4:0] OP_SLTU  = 5'd5;
  localparam logic [4:0] OP_XOR   = 5'd6;
  localparam logic [4:0] OP_SRL   = 5'd7;
  localparam logic [4:0] OP_SRA   = 5'd8;
  localparam logic [4:0] OP_OR    = 5'd9;
  localparam logic [4:0] OP_AND   = 5'd10;
  localparam logic [4:0] OP_ADDI  = 5'd11;
  localparam logic [4:0] OP_SLTI  = 5'd12;
  localparam logic [4:0] OP_SLTIU = 5'd13;
  localparam logic [4:0] OP_XORI  = 5'd14;
  localparam logic [4:0] OP_ORI   = 5'd15;
  localparam logic [4:0] OP_ANDI  = 5'd16;
  localparam logic [4:0] OP_SLLI  = 5'd17;
  localparam logic [4:0] OP_SRLI  = 5'd18;
  localparam logic [4:0] OP_SRAI  = 5'd19;
  localparam logic [4:0] OP_LUI   = 5'd20;
  localparam logic [4:0] OP_AUIPC = 5'd21;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  localparam logic       TRAP_B   = 1'b1;
  localparam logic [76:0] ILL_MASK = '1;
`else
  localparam logic       TRAP_B   = 1'b0;
  localparam logic [76:0] ILL_MASK = {1'b1, 5'd0, 64'd0, 5'd0, 1'b1, 1'b1};
`endif

  typedef struct packed {
    logic        legal;
    logic [4:0]  op;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_insn;
  logic [31:0] if_pc;
  logic        if_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [4:0]  ex_alu_op;
  logic [31:0] ex_alu_in_0;
  logic [31:0] ex_alu_in_1;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_we;
  logic        ex_illegal;

  int   n_checks = 0;
  int   n_errors = 0;
  logic rdy_seen;

  alu_issue dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .if_insn     (if_insn),
    .if_pc       (if_pc),
    .if_ready    (if_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .flush       (flush),
    .ex_ready    (ex_ready),
    .ex_valid    (ex_valid),
    .ex_alu_op   (ex_alu_op),
    .ex_alu_in_0 (ex_alu_in_0),
    .ex_alu_in_1 (ex_alu_in_1),
    .ex_rd_addr  (ex_rd_addr),
    .ex_rd_we    (ex_rd_we),
    .ex_illegal  (ex_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Instruction assemblers.
  function automatic logic [31:0] i_type(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] auipc(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0010111};
  endfunction

  function automatic logic [76:0] obs();
    return {ex_valid, ex_alu_op, ex_alu_in_0, ex_alu_in_1, ex_rd_addr, ex_rd_we, ex_illegal};
  endfunction

  function automatic logic [76:0] mk(input logic v, input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] rd,
                                     input logic we, input logic ill);
    return {v, op, a, b, rd, we, ill};
  endfunction

  // Reference decode written from the instruction-set rules using field arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] insn, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e;
    logic [31:0] imm, sh, uimm;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    opc  = insn[6:0];
    f3   = insn[14:12];
    f7   = insn[31:25];
    imm  = $signed(insn) >>> 20;
    sh   = (insn >> 20) & 32'h1F;
    uimm = insn >> 12;
    e    = '0;
    e.rd = insn[11:7];
    case (opc)
      7'h13: begin
        e.legal = 1'b1;
        e.in0   = imm;
        e.in1   = r1;
        case (f3)
          3'd0: e.op = OP_ADDI;
          3'd2: e.op = OP_SLTI;
          3'd3: e.op = OP_SLTIU;
          3'd4: e.op = OP_XORI;
          3'd6: e.op = OP_ORI;
          3'd7: e.op = OP_ANDI;
          3'd1: begin e.in0 = sh; e.op = OP_SLLI; e.legal = (f7 == 7'h00); end
          default: begin
            e.in0   = sh;
            e.op    = (f7 == 7'h20) ? OP_SRAI : OP_SRLI;
            e.legal = (f7 == 7'h00) || (f7 == 7'h20);
          end
        endcase
      end
      7'h33: begin
        e.in0 = r1;
        e.in1 = r2;
        if (f7 == 7'h00) begin
          e.legal = 1'b1;
          case (f3)
            3'd0: e.op = OP_ADD;
            3'd1: e.op = OP_SLL;
            3'd2: e.op = OP_SLT;
            3'd3: e.op = OP_SLTU;
            3'd4: e.op = OP_XOR;
            3'd5: e.op = OP_SRL;
            3'd6: e.op = OP_OR;
            default: e.op = OP_AND;
          endcase
        end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
          e.legal = 1'b1;
          e.op    = (f3 == 3'd0) ? OP_SUB : OP_SRA;
        end
      end
      7'h37: begin e.legal = 1'b1; e.op = OP_LUI; e.in0 = uimm; e.in1 = 32'd0; end
      7'h17: begin e.legal = 1'b1; e.op = OP_AUIPC; e.in0 = uimm; e.in1 = pc; end
      default: e.legal = 1'b0;
    endcase
    if (!e.legal) begin
      e.op  = OP_NONE;
      e.in0 = '0;
      e.in1 = '0;
    end
    e.we  = e.legal && (e.rd != 5'd0);
    e.ill = !e.legal;
    return e;
  endfunction

  // Drive one cycle of inputs at the falling edge, capture if_ready, settle past the rising edge.
  task automatic step(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic fl, input logic er);
    @(negedge clk);
    if_valid = v;
    if_insn  = insn;
    if_pc    = pc;
    rs1_data = r1;
    rs2_data = r2;
    flush    = fl;
    ex_ready = er;
    #1 rdy_seen = if_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, i_type(3'd0, 5'd1, 5'd2, 12'h7FF), 32'h40, 32'h1234, 32'h0, 1'b0, 1'b0);
    n_checks++;
    if (ex_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_dirty_load: ex_valid=%b required 1", ex_valid);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 77'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h required 0", obs());
    end
    n_checks++;
    if (if_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_if_ready: got %b required 1", if_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_addi;
    step(1'b1, i_type(3'd0, 5'd5, 5'd1, 12'hFFD), 32'h200, 32'd10, 32'h5A5A, 1'b0, 1'b1);
    n_checks++;
    if (rdy_seen !== 1'b1) begin
      n_errors++;
      $display("FAIL addi_if_ready: got %b required 1", rdy_seen);
    end
    n_checks++;
    if (obs() !== mk(1'b1, OP_ADDI, 32'hFFFF_FFFD, 32'd10, 5'd5, 1'b1, 1'b0)) begin
      n_errors++;
      $display("FAIL addi_issue: got %h required %h", obs(),
               mk(1'b1, OP_ADDI, 32'hFFFF_FFFD, 32'd10, 5'd5, 1'b1, 1'b0));
    end
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    n_checks++;
    if (ex_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL addi_drain: ex_valid=%b required 0", ex_valid);
    end
  endtask

  task automatic test_srai_auipc;
    step(1'b1, {7'b0100000, 5'd4, 5'd2, 3'b101, 5'd3, 7'b0010011}, 32'hFC,
         32'hDEAD_BEEF, 32'h1, 1'b0, 1'b1);
    n_checks++;
    if (obs() !== mk(1'b1, OP_SRAI, 32'd4, 32'hDEAD_BEEF, 5'd3, 1'b1, 1'b0)) begin
      n_errors++;
      $display("FAIL srai_issue: got %h required %h", obs(),
               mk(1'b1, OP_SRAI, 32'd4, 32'hDEAD_BEEF, 5'd3, 1'b1, 1'b0));
    end
    step(1'b1, auipc(5'd7, 20'h12345), 32'h100, 32'h77, 32'h88, 1'b0, 1'b1);
    n_checks++;
    if (obs() !== mk(1'b1, OP_AUIPC, 32'h0001_2345, 32'h100, 5'd7, 1'b1, 1'b0)) begin
      n_errors++;
      $display("FAIL auipc_issue: got %h required %h", obs(),
               mk(1'b1, OP_AUIPC, 32'h0001_2345, 32'h100, 5'd7, 1'b1, 1'b0));
    end
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [76:0] held;
    held = mk(1'b1, OP_SUB, 32'd100, 32'd30, 5'd4, 1'b1, 1'b0);
    step(1'b1, r_type(7'h20, 3'd0, 5'd4, 5'd6, 5'd7), 32'h300, 32'd100, 32'd30, 1'b0, 1'b0);
    n_checks++;
    if (obs() !== held) begin
      n_errors++;
      $display("FAIL stall_load_sub: got %h required %h", obs(), held);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, i_type(3'd4, 5'd8, 5'd9, 12'h0F0), 32'h304, 32'h1111 * (i + 1), 32'hFFFF,
           1'b0, 1'b0);
      n_checks++;
      if (rdy_seen !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_if_ready_%0d: got %b required 0", i, rdy_seen);
      end
      n_checks++;
      if (obs() !== held) begin
        n_errors++;
        $display("FAIL stall_hold_%0d: got %h required %h", i, obs(), held);
      end
    end
    step(1'b1, i_type(3'd4, 5'd8, 5'd9, 12'h0F0), 32'h304, 32'h55, 32'hFFFF, 1'b0, 1'b1);
    n_checks++;
    if (obs() !== mk(1'b1, OP_XORI, 32'hF0, 32'h55, 5'd8, 1'b1, 1'b0)) begin
      n_errors++;
      $display("FAIL stall_release_xori: got %h required %h", obs(),
               mk(1'b1, OP_XORI, 32'hF0, 32'h55, 5'd8, 1'b1, 1'b0));
    end
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    n_checks++;
    if (ex_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_no_duplicate: ex_valid=%b required 0", ex_valid);
    end
  endtask

  task automatic test_flush;
    step(1'b1, r_type(7'h00, 3'd0, 5'd1, 5'd2, 5'd3), 32'h400, 32'd5, 32'd6, 1'b0, 1'b0);
    step(1'b1, i_type(3'd0, 5'd9, 5'd1, 12'h001), 32'h404, 32'd5, 32'd6, 1'b1, 1'b0);
    n_checks++;
    if (ex_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_kill: ex_valid=%b required 0", ex_valid);
    end
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    n_checks++;
    if (ex_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_incoming_dropped: ex_valid=%b required 0", ex_valid);
    end
  endtask

  task automatic test_illegal;
    logic [76:0] expv;
    step(1'b1, 32'h0000_0F80, 32'h500, 32'h99, 32'h98, 1'b0, 1'b1);
    n_checks++;
    if (rdy_seen !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal_consumed: if_ready=%b required 1", rdy_seen);
    end
    expv = mk(TRAP_B, OP_NONE, 32'd0, 32'd0, 5'd31, 1'b0, TRAP_B);
    n_checks++;
    if (((obs() ^ expv) & ILL_MASK) !== 77'd0) begin
      n_errors++;
      $display("FAIL illegal_opcode0: got %h required %h mask %h", obs(), expv, ILL_MASK);
    end
    step(1'b1, r_type(7'h00, 3'd0, 5'd0, 5'd1, 5'd2), 32'h504, 32'd7, 32'd9, 1'b0, 1'b1);
    n_checks++;
    if (obs() !== mk(1'b1, OP_ADD, 32'd7, 32'd9, 5'd0, 1'b0, 1'b0)) begin
      n_errors++;
      $display("FAIL add_x0_no_we: got %h required %h", obs(),
               mk(1'b1, OP_ADD, 32'd7, 32'd9, 5'd0, 1'b0, 1'b0));
    end
    step(1'b1, 32'h4000_1093, 32'h508, 32'd7, 32'd9, 1'b0, 1'b1);
    expv = mk(TRAP_B, OP_NONE, 32'd0, 32'd0, 5'd1, 1'b0, TRAP_B);
    n_checks++;
    if (((obs() ^ expv) & ILL_MASK) !== 77'd0) begin
      n_errors++;
      $display("FAIL illegal_slli_funct7: got %h required %h mask %h", obs(), expv, ILL_MASK);
    end
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    exp_t        q[$];
    exp_t        e;
    logic        exp_rdy;
    logic [31:0] insn;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      insn = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: insn[6:0] = 7'b0010011;
        4, 5, 6:    insn[6:0] = 7'b0110011;
        7:          insn[6:0] = 7'b0110111;
        8:          insn[6:0] = 7'b0010111;
        default:    ;
      endcase
      case ($urandom_range(0, 3))
        0, 1:    insn[31:25] = 7'b0000000;
        2:       insn[31:25] = 7'b0100000;
        default: ;
      endcase
      if_insn  = insn;
      if_valid = ($urandom_range(0, 9) < 7);
      if_pc    = $urandom & 32'hFFFF_FFFC;
      rs1_data = $urandom;
      rs2_data = $urandom;
      ex_ready = ($urandom_range(0, 9) < 6);
      flush    = ($urandom_range(0, 19) == 0);
      #1;
      exp_rdy = (q.size() == 0) || ex_ready;
      n_checks++;
      if (if_ready !== exp_rdy) begin
        n_errors++;
        $display("FAIL rand_if_ready cyc %0d: got %b required %b", cyc, if_ready, exp_rdy);
      end
      n_checks++;
      if (rs1_addr !== insn[19:15] || rs2_addr !== insn[24:20]) begin
        n_errors++;
        $display("FAIL rand_rs_addr cyc %0d: got %0d/%0d required %0d/%0d", cyc,
                 rs1_addr, rs2_addr, insn[19:15], insn[24:20]);
      end
      n_checks++;
      if (ex_valid !== (q.size() != 0)) begin
        n_errors++;
        $display("FAIL rand_ex_valid cyc %0d: got %b required %b", cyc, ex_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        n_checks++;
        if (obs() !== mk(1'b1, q[0].op, q[0].in0, q[0].in1, q[0].rd, q[0].we, q[0].ill)) begin
          n_errors++;
          $display("FAIL rand_payload cyc %0d: got %h required %h", cyc, obs(),
                   mk(1'b1, q[0].op, q[0].in0, q[0].in1, q[0].rd, q[0].we, q[0].ill));
        end
      end
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && ex_ready) void'(q.pop_front());
        if (if_valid && exp_rdy) begin
          e = ref_decode(insn, if_pc, rs1_data, rs2_data);
          if (e.legal || TRAP_B) q.push_back(e);
        end
      end
      @(posedge clk);
    end
  endtask

  initial begin
    rst      = 1'b1;
    if_valid = 1'b0;
    if_insn  = 32'h0;
    if_pc    = 32'h0;
    rs1_data = 32'h0;
    rs2_data = 32'h0;
    flush    = 1'b0;
    ex_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    test_reset();
    test_addi();
    test_srai_auipc();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
